// File: rtl/rvb_bmat_pkg.sv
// Shared types and constants for the bmat issue queue: the queued operand
// set and the instruction-bit-14 function select encodings.
package rvb_bmat_pkg;

  localparam logic BMAT_FN_OR  = 1'b0;
  localparam logic BMAT_FN_XOR = 1'b1;

  typedef struct packed {
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic        insn14;
  } rvb_bmat_entry_t;

endpackage

// File: rtl/rvb_bmat_issue_mem.sv
// Operand storage for the bmat issue queue: DEPTH entries, one synchronous
// write port and one asynchronous read port. Contents are intentionally not reset.
module rvb_bmat_issue_mem
  import rvb_bmat_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  rvb_bmat_entry_t            wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output rvb_bmat_entry_t            rd_data
);

  rvb_bmat_entry_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rvb_bmat_issue.sv
// Operand FIFO between the decoder and the bmatxor core.
// Optional macro RVB_BMAT_ISSUE_BYPASS_EN adds an empty-queue din-to-dout bypass.
module rvb_bmat_issue
  import rvb_bmat_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         din_valid,
  output logic                         din_ready,
  input  logic [63:0]                  din_rs1,
  input  logic [63:0]                  din_rs2,
  input  logic                         din_insn14,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic [63:0]                  dout_rs1,
  output logic [63:0]                  dout_rs2,
  output logic                         dout_insn14,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            empty;
  logic            bypass;
  logic            push;
  logic            pop;
  logic            wr_en;
  rvb_bmat_entry_t din_e;
  rvb_bmat_entry_t head_e;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign din_e = '{rs1: din_rs1, rs2: din_rs2, insn14: din_insn14};
  assign empty = (cnt_q == '0);

  // din_ready depends only on local state so no path exists from dout_ready.
  assign din_ready = resetn && !flush && (cnt_q < FULL);

`ifdef RVB_BMAT_ISSUE_BYPASS_EN
  assign bypass = resetn && empty && din_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign dout_valid = (resetn && !empty) || bypass;
  assign push       = din_valid && din_ready;
  assign pop        = resetn && !empty && dout_ready;
  // A bypassed operand consumed downstream the same cycle never lands in storage.
  assign wr_en      = push && !(bypass && dout_ready);

  always_comb begin
    dout_rs1    = head_e.rs1;
    dout_rs2    = head_e.rs2;
    dout_insn14 = head_e.insn14;
    if (bypass) begin
      dout_rs1    = din_rs1;
      dout_rs2    = din_rs2;
      dout_insn14 = din_insn14;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      cnt_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (wr_en) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  assign count = cnt_q;

  rvb_bmat_issue_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (din_e),
    .rd_addr (rd_ptr),
    .rd_data (head_e)
  );

endmodule

// File: tb/tb_rvb_bmat_issue.sv
// Self-checking bench for rvb_bmat_issue: directed scenarios plus random
// traffic checked against a queue-based reference model.
module tb_rvb_bmat_issue;
  import rvb_bmat_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW = $clog2(DEPTH + 1);
`ifdef RVB_BMAT_ISSUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          flush = 1'b0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [63:0]   din_rs1 = '0;
  logic [63:0]   din_rs2 = '0;
  logic          din_insn14 = 1'b0;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic [63:0]   dout_rs1;
  logic [63:0]   dout_rs2;
  logic          dout_insn14;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;
  int unsigned n_pops = 0;
  rvb_bmat_entry_t model_q[$];

  rvb_bmat_issue #(
    .DEPTH(DEPTH)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .flush       (flush),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .din_rs1     (din_rs1),
    .din_rs2     (din_rs2),
    .din_insn14  (din_insn14),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_rs1    (dout_rs1),
    .dout_rs2    (dout_rs2),
    .dout_insn14 (dout_insn14),
    .count       (count)
  );

  always #5 clock = ~clock;

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Boolean (OR) or GF(2) (XOR) 8x8 bit-matrix product, as the core computes.
  function automatic logic [63:0] bmat(input logic [63:0] a, input logic [63:0] b, input logic x);
    logic [63:0] r;
    logic acc;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        acc = 1'b0;
        for (int k = 0; k < 8; k++) begin
          if (a[8*i+k] && b[8*k+j]) acc = x ? ~acc : 1'b1;
        end
        r[8*i+j] = acc;
      end
    end
    return r;
  endfunction

  // Check outputs against the model, then advance one clock and update the model.
  task automatic cycle(input string tag);
    bit exp_rdy;
    bit exp_vld;
    bit byp;
    rvb_bmat_entry_t din_e;
    rvb_bmat_entry_t head;
    din_e = '{rs1: din_rs1, rs2: din_rs2, insn14: din_insn14};
    #1;
    byp     = BYPASS && (model_q.size() == 0) && din_valid && !flush;
    exp_rdy = !flush && (model_q.size() < DEPTH);
    exp_vld = (model_q.size() != 0) || byp;
    head    = byp ? din_e : (model_q.size() != 0 ? model_q[0] : din_e);
    check64({tag, "_din_ready"}, 64'(din_ready), 64'(exp_rdy));
    check64({tag, "_dout_valid"}, 64'(dout_valid), 64'(exp_vld));
    check64({tag, "_count"}, 64'(count), 64'(model_q.size()));
    if (exp_vld) begin
      check64({tag, "_rs1"}, dout_rs1, head.rs1);
      check64({tag, "_rs2"}, dout_rs2, head.rs2);
      check64({tag, "_insn14"}, 64'(dout_insn14), 64'(head.insn14));
    end
    @(posedge clock);
    if (exp_vld && dout_ready) begin
      n_pops++;
      if (!byp) void'(model_q.pop_front());
    end
    if (flush) begin
      model_q.delete();
    end else if (din_valid && exp_rdy && !(byp && dout_ready)) begin
      model_q.push_back(din_e);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b, input logic f);
    din_valid  = v;
    din_rs1    = a;
    din_rs2    = b;
    din_insn14 = f;
  endtask

  initial begin
    int unsigned pops0;

    // Reset state
    #3;
    check64("rst_din_ready", 64'(din_ready), 64'd0);
    check64("rst_dout_valid", 64'(dout_valid), 64'd0);
    check64("rst_count", 64'(count), 64'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    #1;
    check64("post_rst_din_ready", 64'(din_ready), 64'd1);
    check64("post_rst_dout_valid", 64'(dout_valid), 64'd0);

    // Fill to full with the core stalled
    dout_ready = 1'b0;
    drive(1'b1, 64'h0102040810204080, '1, BMAT_FN_OR);
    cycle("fill0");
    drive(1'b1, 64'h8040201008040201, '1, BMAT_FN_OR);
    cycle("fill1");
    drive(1'b0, '0, '0, 1'b0);
    cycle("full");
    check64("full_count", 64'(count), 64'd2);
    check64("full_din_ready", 64'(din_ready), 64'd0);
    check64("full_head_rs1", dout_rs1, 64'h0102040810204080);

    // Drain in order; first entry through the core model
    dout_ready = 1'b1;
    #1;
    check64("chain_result", bmat(dout_rs1, dout_rs2, dout_insn14), 64'hFFFFFFFFFFFFFFFF);
    cycle("drain0");
    check64("drain1_rs1", dout_rs1, 64'h8040201008040201);
    cycle("drain1");
    cycle("drained");
    check64("drained_count", 64'(count), 64'd0);
    check64("drained_valid", 64'(dout_valid), 64'd0);

    // Steady streaming at occupancy 1
    dout_ready = 1'b0;
    drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    cycle("stream_prime");
    dout_ready = 1'b1;
    pops0 = n_pops;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      cycle("stream");
      check64("stream_count", 64'(count), 64'd1);
    end
    check64("stream_delivered", 64'(n_pops - pops0), 64'd10);

    // Flush while pushing into a full queue
    dout_ready = 1'b0;
    drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    cycle("pre_flush");
    flush = 1'b1;
    cycle("flush");
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    check64("flush_count", 64'(count), 64'd0);
    check64("flush_valid", 64'(dout_valid), 64'd0);
    cycle("post_flush");

    // Asynchronous reset mid-cycle with one entry queued
    drive(1'b1, 64'h55, 64'hAA, BMAT_FN_XOR);
    cycle("pre_areset");
    drive(1'b0, '0, '0, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check64("areset_valid", 64'(dout_valid), 64'd0);
    check64("areset_count", 64'(count), 64'd0);
    check64("areset_din_ready", 64'(din_ready), 64'd0);
    model_q.delete();
    @(posedge clock);
    #1;
    resetn = 1'b1;
    cycle("post_areset");
    check64("post_areset_count", 64'(count), 64'd0);

    // Empty-queue latency (bypass or one cycle)
    dout_ready = 1'b1;
    drive(1'b1, 64'h1234, 64'h0, BMAT_FN_OR);
    cycle("lat0");
    drive(1'b0, '0, '0, 1'b0);
    #1;
    check64("lat_count", 64'(count), BYPASS ? 64'd0 : 64'd1);
    cycle("lat1");

    // Random traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      dout_ready = ($urandom % 3) != 0;
      flush = ($urandom % 25) == 0;
      cycle("rand");
    end
    flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
